// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction and branch resolution.
// Optional PCU_PERF_CNT_EN adds branch / mispredict performance counters.
module pc_predict_unit #(
    parameter int              PC_W      = 16,
    parameter int              BTB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic [2:0]      res_cond,
    input  logic [2:0]      res_flags,
    input  logic            res_type,
    input  logic [8:0]      res_imm,
    input  logic [PC_W-1:0] res_reg,
    input  logic            res_pred_taken,
    input  logic [PC_W-1:0] res_pred_target,
    output logic            branch_taken,
    output logic            flush
`ifdef PCU_PERF_CNT_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     mispred_count
`endif
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 1;
    localparam int EXT_W = PC_W - 10;

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [PC_W-1:0]      btb_tgt [BTB_DEPTH];
    logic [1:0]           btb_ctr [BTB_DEPTH];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [PC_W-1:0]  pc_inc;

    logic [IDX_W-1:0] ridx;
    logic [TAG_W-1:0] rtag;
    logic [PC_W-1:0]  res_inc;
    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  actual_tgt;
    logic             cond_met;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [PC_W-1:0]  pc_next;

    // Fetch-side lookup: halfword-aligned PCs, bit 0 ignored for indexing
    assign idx         = pc[IDX_W:1];
    assign tag         = pc[PC_W-1:IDX_W+1];
    assign hit         = btb_valid[idx] & (btb_tag[idx] == tag);
    assign pc_inc      = pc + PC_W'(2);
    assign pred_taken  = hit & btb_ctr[idx][1];
    assign pred_target = pred_taken ? btb_tgt[idx] : pc_inc;

    assign ridx    = res_pc[IDX_W:1];
    assign rtag    = res_pc[PC_W-1:IDX_W+1];
    assign res_inc = res_pc + PC_W'(2);
    assign imm_ext = {{EXT_W{res_imm[8]}}, res_imm, 1'b0};

    assign flag_z = res_flags[0];
    assign flag_n = res_flags[1];
    assign flag_v = res_flags[2];

    always_comb begin
        cond_met = 1'b0;
        unique case (res_cond)
            3'b000: cond_met = ~flag_z;
            3'b001: cond_met = flag_z;
            3'b010: cond_met = ~flag_n & ~flag_z;
            3'b011: cond_met = flag_n;
            3'b100: cond_met = flag_z | ~flag_n;
            3'b101: cond_met = flag_n | flag_z;
            3'b110: cond_met = flag_v;
            3'b111: cond_met = 1'b1;
        endcase
    end

    assign actual_tgt   = res_type ? res_reg : (res_inc + imm_ext);
    assign branch_taken = res_valid & cond_met;
    assign flush = res_valid &
                   ((branch_taken != res_pred_taken) |
                    (branch_taken & (actual_tgt != res_pred_target)));

    // A redirect beats stall/halt: anything held in fetch is wrong-path
    always_comb begin
        pc_next = pred_target;
        if (flush) begin
            pc_next = branch_taken ? actual_tgt : res_inc;
        end else if (halt | stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_ctr[i] <= 2'b01;
            end
        end else if (res_valid) begin
            if (branch_taken) begin
                if (btb_ctr[ridx] != 2'b11) begin
                    btb_ctr[ridx] <= btb_ctr[ridx] + 2'd1;
                end
                btb_valid[ridx] <= 1'b1;
                btb_tag[ridx]   <= rtag;
                btb_tgt[ridx]   <= actual_tgt;
            end else if (btb_ctr[ridx] != 2'b00) begin
                btb_ctr[ridx] <= btb_ctr[ridx] - 2'd1;
            end
        end
    end

`ifdef PCU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (res_valid && br_count != 16'hFFFF) begin
                br_count <= br_count + 16'd1;
            end
            if (flush && mispred_count != 16'hFFFF) begin
                mispred_count <= mispred_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        res_valid = 1'b0;
    logic [15:0] res_pc = '0;
    logic [2:0]  res_cond = '0;
    logic [2:0]  res_flags = '0;
    logic        res_type = 1'b0;
    logic [8:0]  res_imm = '0;
    logic [15:0] res_reg = '0;
    logic        res_pred_taken = 1'b0;
    logic [15:0] res_pred_target = '0;
    logic        branch_taken;
    logic        flush;
`ifdef PCU_PERF_CNT_EN
    logic [15:0] br_count;
    logic [15:0] mispred_count;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        pt;
        logic [15:0] ptgt;
        logic        fl;
        logic        bt;
    } exp_t;

    exp_t sb[$];

    pc_predict_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .halt(halt),
        .pc(pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .res_valid(res_valid),
        .res_pc(res_pc),
        .res_cond(res_cond),
        .res_flags(res_flags),
        .res_type(res_type),
        .res_imm(res_imm),
        .res_reg(res_reg),
        .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target),
        .branch_taken(branch_taken),
        .flush(flush)
`ifdef PCU_PERF_CNT_EN
        ,
        .br_count(br_count),
        .mispred_count(mispred_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (pc !== e.pc || pred_taken !== e.pt || pred_target !== e.ptgt ||
                flush !== e.fl || branch_taken !== e.bt) begin
                fails++;
                $display("FAIL %s: got pc=%h pt=%b ptgt=%h fl=%b bt=%b want pc=%h pt=%b ptgt=%h fl=%b bt=%b",
                         e.name, pc, pred_taken, pred_target, flush, branch_taken,
                         e.pc, e.pt, e.ptgt, e.fl, e.bt);
            end
        end
    end

    task automatic set_res(input logic [15:0] rpc, input logic [2:0] c,
                           input logic [2:0] f, input logic t,
                           input logic [8:0] imm, input logic [15:0] rr,
                           input logic pt, input logic [15:0] ptgt);
        res_valid       = 1'b1;
        res_pc          = rpc;
        res_cond        = c;
        res_flags       = f;
        res_type        = t;
        res_imm         = imm;
        res_reg         = rr;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
    endtask

    task automatic clr_res();
        res_valid = 1'b0;
    endtask

    // Expectation for the current cycle, then advance past the next edge
    task automatic cyc(input string n, input logic [15:0] epc, input logic ept,
                       input logic [15:0] eptgt, input logic efl, input logic ebt);
        exp_t e;
        e.name = n;
        e.pc   = epc;
        e.pt   = ept;
        e.ptgt = eptgt;
        e.fl   = efl;
        e.bt   = ebt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset", 16'h0000, 0, 16'h0002, 0, 0);
        rst = 1'b0;
        cyc("seq0", 16'h0000, 0, 16'h0002, 0, 0);
        cyc("seq2", 16'h0002, 0, 16'h0004, 0, 0);
        cyc("seq4", 16'h0004, 0, 16'h0006, 0, 0);
        stall = 1'b1;
        cyc("stall_a", 16'h0006, 0, 16'h0008, 0, 0);
        cyc("stall_b", 16'h0006, 0, 16'h0008, 0, 0);
        stall = 1'b0;
        halt  = 1'b1;
        cyc("halt", 16'h0006, 0, 16'h0008, 0, 0);
        halt = 1'b0;
        cyc("resume", 16'h0006, 0, 16'h0008, 0, 0);

        set_res(16'h0008, 3'b111, 3'b000, 1'b0, 9'h004, 16'h0000, 1'b0, 16'h000A);
        cyc("b_always", 16'h0008, 0, 16'h000A, 1, 1);
        clr_res();
        cyc("redir12", 16'h0012, 0, 16'h0014, 0, 0);
        set_res(16'h0020, 3'b111, 3'b000, 1'b1, 9'h000, 16'h0008, 1'b0, 16'h0022);
        cyc("br_to8", 16'h0014, 0, 16'h0016, 1, 1);
        clr_res();
        cyc("revisit8", 16'h0008, 1, 16'h0012, 0, 0);

        set_res(16'h0008, 3'b001, 3'b001, 1'b1, 9'h000, 16'h0100, 1'b1, 16'h0200);
        cyc("br_eq", 16'h0012, 0, 16'h0014, 1, 1);
        set_res(16'h0006, 3'b000, 3'b001, 1'b0, 9'h000, 16'h0000, 1'b1, 16'h0040);
        cyc("nt_flush", 16'h0100, 0, 16'h0102, 1, 0);
        clr_res();
        cyc("rewrite8", 16'h0008, 1, 16'h0100, 0, 0);

        set_res(16'h000C, 3'b111, 3'b000, 1'b0, 9'h1FF, 16'h0000, 1'b1, 16'h000C);
        cyc("train1", 16'h0100, 0, 16'h0102, 0, 1);
        cyc("train2", 16'h0102, 0, 16'h0104, 0, 1);
        cyc("train3", 16'h0104, 0, 16'h0106, 0, 1);
        set_res(16'h000C, 3'b000, 3'b001, 1'b0, 9'h1FF, 16'h0000, 1'b0, 16'h000E);
        cyc("train_nt", 16'h0106, 0, 16'h0108, 0, 0);
        set_res(16'h0030, 3'b111, 3'b000, 1'b1, 9'h000, 16'h000C, 1'b0, 16'h0032);
        cyc("br_to0c", 16'h0108, 0, 16'h010A, 1, 1);
        set_res(16'h000C, 3'b000, 3'b001, 1'b0, 9'h1FF, 16'h0000, 1'b1, 16'h000C);
        cyc("still_taken", 16'h000C, 1, 16'h000C, 1, 0);

        stall = 1'b1;
        halt  = 1'b1;
        set_res(16'h0040, 3'b010, 3'b000, 1'b0, 9'h002, 16'h0000, 1'b0, 16'h0042);
        cyc("nt_redir_stall", 16'h000E, 0, 16'h0010, 1, 1);
        clr_res();
        cyc("flush_wins", 16'h0046, 0, 16'h0048, 0, 0);
        stall = 1'b0;
        halt  = 1'b0;
`ifdef PCU_PERF_CNT_EN
        tests++;
        if (br_count !== 16'd11 || mispred_count !== 16'd7) begin
            fails++;
            $display("FAIL perf: got br=%0d mis=%0d want br=11 mis=7",
                     br_count, mispred_count);
        end
`endif
        cyc("held", 16'h0046, 0, 16'h0048, 0, 0);

        rst = 1'b1;
        cyc("mid_reset", 16'h0048, 0, 16'h004A, 0, 0);
        rst = 1'b0;
`ifdef PCU_PERF_CNT_EN
        tests++;
        if (br_count !== 16'd0 || mispred_count !== 16'd0) begin
            fails++;
            $display("FAIL perf_rst: got br=%0d mis=%0d want 0 0",
                     br_count, mispred_count);
        end
`endif
        cyc("post0", 16'h0000, 0, 16'h0002, 0, 0);
        cyc("post2", 16'h0002, 0, 16'h0004, 0, 0);
        cyc("post4", 16'h0004, 0, 16'h0006, 0, 0);
        cyc("post6", 16'h0006, 0, 16'h0008, 0, 0);
        cyc("post8_cleared", 16'h0008, 0, 16'h000A, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
